// File: rtl/lift_call_dispatcher.sv
// lift_call_dispatcher: latches hall/cabin calls and offers one SCAN-selected target floor at a time.
// Optional SERVE watchdog is built only when DISPATCH_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | no target outstanding; retire same-floor calls or pick next
// S_ISSUE | target offered, held until the lift controller accepts it
// S_SERVE | target accepted, waiting for the lift to stop at that floor
module lift_call_dispatcher #(
  parameter int N_FLOORS    = 8,
  parameter int FW          = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [N_FLOORS-1:0] i_hall_btn,
  input  logic [N_FLOORS-1:0] i_cab_btn,
  input  logic [FW-1:0]       i_elev_f,
  input  logic                i_busy,
  input  logic                i_req_ready,
  output logic                o_req_valid,
  output logic [FW-1:0]       o_req_floor,
  output logic [N_FLOORS-1:0] o_pending,
  output logic                o_dir,
  output logic                o_arrive,
  output logic                o_fault
);

  if ((1 << FW) < N_FLOORS) begin : g_bad_fw
    $error("lift_call_dispatcher: FW too narrow for N_FLOORS");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("lift_call_dispatcher: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_SERVE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_FLOORS-1:0] r_pend;
  logic [FW-1:0]       r_target;
  logic                r_dir;
  logic                r_arrive;
  logic                r_serve_armed;

  logic                w_up_found;
  logic [FW-1:0]       w_up_floor;
  logic                w_dn_found;
  logic [FW-1:0]       w_dn_floor;
  logic                w_sel_valid;
  logic                w_sel_dir;
  logic [FW-1:0]       w_sel_floor;
  logic                w_elev_ok;
  logic                w_here;
  logic                w_arrival;
  logic                w_wd_expired;
  logic                w_load_tgt;
  logic                w_retire;
  logic [FW-1:0]       w_retire_floor;
  logic [N_FLOORS-1:0] w_set;
  logic [N_FLOORS-1:0] w_clr;

  // Nearest pending floor strictly above and strictly below the cabin.
  always_comb begin
    w_up_found = 1'b0;
    w_up_floor = '0;
    w_dn_found = 1'b0;
    w_dn_floor = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (r_pend[i] && (i > int'(i_elev_f))) begin
        w_up_found = 1'b1;
        w_up_floor = FW'(i);
      end
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (r_pend[i] && (i < int'(i_elev_f))) begin
        w_dn_found = 1'b1;
        w_dn_floor = FW'(i);
      end
    end
  end

  // Keep the current direction while it has work, otherwise reverse.
  always_comb begin
    w_sel_valid = w_up_found | w_dn_found;
    w_sel_dir   = r_dir;
    w_sel_floor = w_up_floor;
    if (r_dir) begin
      w_sel_dir   = w_up_found;
      w_sel_floor = w_up_found ? w_up_floor : w_dn_floor;
    end else begin
      w_sel_dir   = ~w_dn_found;
      w_sel_floor = w_dn_found ? w_dn_floor : w_up_floor;
    end
  end

  assign w_elev_ok = int'(i_elev_f) < N_FLOORS;
  assign w_here    = w_elev_ok && r_pend[i_elev_f];

  // The first SERVE cycle is skipped so a stale stopped-at-target report is not taken as arrival.
  assign w_arrival = (r_state == S_SERVE) && r_serve_armed && !i_busy &&
                     (i_elev_f == r_target);

  always_comb begin
    w_state_nxt    = r_state;
    w_load_tgt     = 1'b0;
    w_retire       = 1'b0;
    w_retire_floor = r_target;
    unique case (r_state)
      S_IDLE: begin
        if (!i_busy && w_here) begin
          w_retire       = 1'b1;
          w_retire_floor = i_elev_f;
        end else if (w_sel_valid) begin
          w_load_tgt  = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_req_ready) begin
          w_state_nxt = S_SERVE;
        end
      end
      S_SERVE: begin
        if (w_arrival) begin
          w_retire    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_wd_expired) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_set = i_hall_btn | i_cab_btn;
  assign w_clr = w_retire ? (N_FLOORS'(1) << w_retire_floor) : '0;

  // Clear is applied after set: a press at the open door is absorbed.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend        <= '0;
      r_target      <= '0;
      r_dir         <= 1'b1;
      r_arrive      <= 1'b0;
      r_serve_armed <= 1'b0;
    end else begin
      r_pend        <= (r_pend | w_set) & ~w_clr;
      r_arrive      <= w_retire;
      r_serve_armed <= (r_state == S_SERVE);
      if (w_load_tgt) begin
        r_target <= w_sel_floor;
        r_dir    <= w_sel_dir;
      end
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_fault;

  assign w_wd_expired = (r_state == S_SERVE) && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd_cnt <= '0;
      r_fault  <= 1'b0;
    end else begin
      if ((r_state == S_ISSUE) && i_req_ready) begin
        r_wd_cnt <= '0;
      end else if (r_state == S_SERVE) begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      if (w_wd_expired && !w_arrival) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign o_fault = r_fault;
`else
  assign w_wd_expired = 1'b0;
  assign o_fault      = 1'b0;
`endif

  assign o_req_valid = (r_state == S_ISSUE);
  assign o_req_floor = r_target;
  assign o_pending   = r_pend;
  assign o_dir       = r_dir;
  assign o_arrive    = r_arrive;

endmodule

// File: tb/tb_lift_call_dispatcher.sv
// Bench for lift_call_dispatcher: directed scenarios plus random traffic against a behavioural SCAN model.
`timescale 1ns/1ps
module tb_lift_call_dispatcher;

  localparam int N  = 8;
  localparam int FW = 3;
  localparam int TO = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_OFFER = 1;
  localparam int PH_SERVE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  hall;
  logic [N-1:0]  cab;
  logic [FW-1:0] elev;
  logic          busy;
  logic          ready;
  logic          o_req_valid;
  logic [FW-1:0] o_req_floor;
  logic [N-1:0]  o_pending;
  logic          o_dir;
  logic          o_arrive;
  logic          o_fault;

  always #5 clk = ~clk;

  lift_call_dispatcher #(.N_FLOORS(N), .FW(FW), .TIMEOUT_CYC(TO)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_hall_btn  (hall),
    .i_cab_btn   (cab),
    .i_elev_f    (elev),
    .i_busy      (busy),
    .i_req_ready (ready),
    .o_req_valid (o_req_valid),
    .o_req_floor (o_req_floor),
    .o_pending   (o_pending),
    .o_dir       (o_dir),
    .o_arrive    (o_arrive),
    .o_fault     (o_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a set of called floors plus what the lift is currently doing.
  bit m_pend[N];
  int m_phase   = PH_IDLE;
  int m_tgt     = 0;
  bit m_dir     = 1'b1;
  bit m_arrive  = 1'b0;
  bit m_fault   = 1'b0;
  int m_serve_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int nearest(input int from, input bit up);
    for (int d = 1; d < N; d++) begin
      int f;
      f = up ? from + d : from - d;
      if (f >= 0 && f < N && m_pend[f]) return f;
    end
    return -1;
  endfunction

  task automatic model_step();
    bit np[N];
    int nphase, ntgt, nserve, e, f;
    bit ndir, narr, nfault, d;
    if (rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_phase = PH_IDLE; m_tgt = 0; m_dir = 1'b1;
      m_arrive = 1'b0; m_fault = 1'b0; m_serve_n = 0;
      return;
    end
    for (int i = 0; i < N; i++) np[i] = m_pend[i] | hall[i] | cab[i];
    nphase = m_phase; ntgt = m_tgt; ndir = m_dir; narr = 1'b0;
    nfault = m_fault; nserve = m_serve_n;
    e = int'(elev);
    if (m_phase == PH_IDLE) begin
      if (!busy && e < N && m_pend[e]) begin
        np[e] = 1'b0;
        narr  = 1'b1;
      end else begin
        d = m_dir;
        f = nearest(e, d);
        if (f < 0) begin
          d = !m_dir;
          f = nearest(e, d);
        end
        if (f >= 0) begin
          ntgt = f; ndir = d; nphase = PH_OFFER;
        end
      end
    end else if (m_phase == PH_OFFER) begin
      if (ready) begin
        nphase = PH_SERVE;
        nserve = 0;
      end
    end else begin
      nserve = m_serve_n + 1;
      if (nserve >= 2 && !busy && e == m_tgt) begin
        np[m_tgt] = 1'b0;
        narr   = 1'b1;
        nphase = PH_IDLE;
      end
`ifdef DISPATCH_TIMEOUT_EN
      else if (nserve == TO) begin
        nfault = 1'b1;
        nphase = PH_IDLE;
      end
`endif
    end
    m_pend = np; m_phase = nphase; m_tgt = ntgt; m_dir = ndir;
    m_arrive = narr; m_fault = nfault; m_serve_n = nserve;
  endtask

  task automatic check_model();
    logic [N-1:0] ep;
    for (int i = 0; i < N; i++) ep[i] = m_pend[i];
    check_eq("pending", o_pending, ep);
    check_eq("req_valid", o_req_valid, m_phase == PH_OFFER);
    if (m_phase == PH_OFFER) check_eq("req_floor", o_req_floor, m_tgt);
    check_eq("dir", o_dir, m_dir);
    check_eq("arrive", o_arrive, m_arrive);
    check_eq("fault", o_fault, m_fault);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic quiet();
    hall  = '0;
    cab   = '0;
    ready = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "bench time limit");
  end

  initial begin
    int  mv_left, hold;
    bit  moving;
    logic [FW-1:0] dest;
    quiet();
    rst = 1'b1; elev = '0; busy = 1'b0;

    // Reset state and single request
    do_reset();
    check_eq("rst_pending", o_pending, 8'h00);
    check_eq("rst_valid", o_req_valid, 1'b0);
    check_eq("rst_dir", o_dir, 1'b1);
    check_eq("rst_arrive", o_arrive, 1'b0);
    check_eq("rst_fault", o_fault, 1'b0);
    cab[5] = 1'b1; tick(); cab = '0;
    check_eq("t1_pending", o_pending, 8'h20);
    check_eq("t1_valid_early", o_req_valid, 1'b0);
    tick();
    check_eq("t1_valid", o_req_valid, 1'b1);
    check_eq("t1_floor", o_req_floor, 3'd5);
    ready = 1'b1; tick(); ready = 1'b0;
    busy = 1'b1;
    repeat (10) tick();
    busy = 1'b0; elev = 3'd5; tick();
    check_eq("t1_arrive", o_arrive, 1'b1);
    check_eq("t1_pend_clr", o_pending, 8'h00);
    tick();
    check_eq("t1_arrive_once", o_arrive, 1'b0);

    // SCAN ordering from floor 3 going up
    do_reset();
    elev = 3'd3;
    hall[1] = 1'b1; hall[6] = 1'b1; tick(); hall = '0;
    tick();
    check_eq("t2_floor_a", o_req_floor, 3'd6);
    check_eq("t2_dir_a", o_dir, 1'b1);
    ready = 1'b1; tick(); ready = 1'b0;
    busy = 1'b1; repeat (3) tick();
    busy = 1'b0; elev = 3'd6; tick();
    check_eq("t2_arrive6", o_arrive, 1'b1);
    tick();
    check_eq("t2_valid_b", o_req_valid, 1'b1);
    check_eq("t2_floor_b", o_req_floor, 3'd1);
    check_eq("t2_dir_b", o_dir, 1'b0);
    ready = 1'b1; tick(); ready = 1'b0;
    busy = 1'b1; repeat (2) tick();
    busy = 1'b0; elev = 3'd1; tick();
    check_eq("t2_arrive1", o_arrive, 1'b1);
    tick();

    // Same-floor press
    elev = 3'd2;
    hall[2] = 1'b1; tick(); hall = '0;
    check_eq("t3_arrive_early", o_arrive, 1'b0);
    check_eq("t3_pending", o_pending, 8'h04);
    tick();
    check_eq("t3_arrive", o_arrive, 1'b1);
    check_eq("t3_no_valid", o_req_valid, 1'b0);
    check_eq("t3_pend_clr", o_pending, 8'h00);
    tick();
    check_eq("t3_no_valid2", o_req_valid, 1'b0);

    // Handshake hold while another floor is called
    elev = 3'd0;
    cab[4] = 1'b1; tick(); cab = '0;
    tick();
    cab[7] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check_eq("t4_hold_floor", o_req_floor, 3'd4);
      check_eq("t4_hold_valid", o_req_valid, 1'b1);
    end
    cab = '0;
    check_eq("t4_pending", o_pending, 8'h90);

    // Set/clear conflict at arrival, then reset during ISSUE
    ready = 1'b1; tick(); ready = 1'b0;
    busy = 1'b1; repeat (3) tick();
    busy = 1'b0; elev = 3'd4; hall[4] = 1'b1; tick(); hall = '0;
    check_eq("t5_arrive", o_arrive, 1'b1);
    check_eq("t5_conflict", o_pending, 8'h80);
    tick();
    check_eq("t5_valid7", o_req_valid, 1'b1);
    check_eq("t5_floor7", o_req_floor, 3'd7);
    do_reset();
    check_eq("t5_rst_valid", o_req_valid, 1'b0);
    check_eq("t5_rst_pending", o_pending, 8'h00);

`ifdef DISPATCH_TIMEOUT_EN
    // Watchdog expiry while the lift never reports arrival
    elev = 3'd0; busy = 1'b0;
    cab[3] = 1'b1; tick(); cab = '0;
    tick();
    ready = 1'b1; tick(); ready = 1'b0;
    busy = 1'b1;
    repeat (TO - 1) tick();
    check_eq("t6_fault_early", o_fault, 1'b0);
    tick();
    check_eq("t6_fault", o_fault, 1'b1);
    check_eq("t6_idle", o_req_valid, 1'b0);
    check_eq("t6_kept", o_pending, 8'h08);
    tick();
    check_eq("t6_reissue", o_req_floor, 3'd3);
    busy = 1'b0;
    do_reset();
    check_eq("t6_rst_fault", o_fault, 1'b0);
`endif

    // Random traffic against the model
    do_reset();
    moving = 1'b0; mv_left = 0; hold = 0; dest = '0;
    for (int c = 0; c < 3000; c++) begin
      quiet();
      if ($urandom_range(0, 5) == 0) hall[$urandom_range(0, N - 1)] = 1'b1;
      if ($urandom_range(0, 7) == 0) cab[$urandom_range(0, N - 1)] = 1'b1;
      rst = ($urandom_range(0, 399) == 0);
      if (moving) begin
        if (mv_left == 0) begin
          elev = dest; busy = 1'b0; moving = 1'b0; hold = 2;
        end else begin
          mv_left--;
          busy = 1'b1;
          if ($urandom_range(0, 2) == 0) elev = FW'($urandom_range(0, N - 1));
        end
      end else if (hold > 0) begin
        hold--;
        busy = 1'b0;
      end else begin
        busy = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 19) == 0) elev = FW'($urandom_range(0, N - 1));
        if (o_req_valid) ready = ($urandom_range(0, 2) == 0);
        if (o_req_valid && ready) begin
          moving  = 1'b1;
          dest    = o_req_floor;
          mv_left = $urandom_range(0, 8);
        end
      end
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
